// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter onto a single 16-bit memory bus.
// One transaction in flight at a time; a watchdog aborts a stalled memory access.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [15:0] r0_addr,
  input  logic [15:0] r0_wdata,
  output logic [15:0] r0_rdata,
  output logic        r0_ack,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [15:0] r1_addr,
  input  logic [15:0] r1_wdata,
  output logic [15:0] r1_rdata,
  output logic        r1_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_ack,
  input  logic [15:0] m_rdata,
  output logic        busy,
  output logic        owner,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        m_req_n, m_we_n, owner_n, err_n, busy_n;
  logic [15:0] m_addr_n, m_wdata_n;
  logic [15:0] r0_rdata_n, r1_rdata_n;
  logic        r0_ack_n, r1_ack_n;
  logic        win, finish;
  logic [15:0] load_val;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    m_req_n    = m_req;
    m_we_n     = m_we;
    m_addr_n   = m_addr;
    m_wdata_n  = m_wdata;
    owner_n    = owner;
    err_n      = err;
    r0_rdata_n = r0_rdata;
    r1_rdata_n = r1_rdata;
    r0_ack_n   = 1'b0;
    r1_ack_n   = 1'b0;
    win        = 1'b0;
    finish     = 1'b0;
    load_val   = '0;

    unique case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          // On a tie the port that did not hold the bus last goes next
          win       = (r0_req && r1_req) ? ~owner : r1_req;
          m_we_n    = win ? r1_we    : r0_we;
          m_addr_n  = win ? r1_addr  : r0_addr;
          m_wdata_n = win ? r1_wdata : r0_wdata;
          m_req_n   = 1'b1;
          owner_n   = win;
          cnt_n     = '0;
          state_n   = BUSY;
        end
      end
      BUSY: begin
        if (m_ack) begin
          finish   = 1'b1;
          load_val = m_rdata;
        end else if (cnt == CNT_LAST) begin
          finish   = 1'b1;
          load_val = '0;
          err_n    = 1'b1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
        if (finish) begin
          if (!m_we) begin
            if (owner) r1_rdata_n = load_val;
            else       r0_rdata_n = load_val;
          end
          r0_ack_n = ~owner;
          r1_ack_n = owner;
          m_req_n  = 1'b0;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      owner    <= 1'b1;
      err      <= 1'b0;
      busy     <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      m_req    <= m_req_n;
      m_we     <= m_we_n;
      m_addr   <= m_addr_n;
      m_wdata  <= m_wdata_n;
      owner    <= owner_n;
      err      <= err_n;
      busy     <= busy_n;
      r0_rdata <= r0_rdata_n;
      r1_rdata <= r1_rdata_n;
      r0_ack   <= r0_ack_n;
      r1_ack   <= r1_ack_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: requester/memory drivers, a transaction-level
// arbitration model feeding a scoreboard, and a monitor that checks every ack.
module tb_mem_arbiter;

  localparam int unsigned TO = 4;

  typedef struct {
    int          port;
    int          due;
    logic [15:0] rdata;
    logic        err;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]       req, we, ack;
  logic [1:0][15:0] addr, wdata, rd;
  logic        m_req, m_we, m_ack, busy, owner, err;
  logic [15:0] m_addr, m_wdata, m_rdata;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  mode = 0;
  bit  run = 1'b0;
  bit  dir_done;
  item_t sbq[$];

  logic [1:0]       req_s, we_s;
  logic [1:0][15:0] addr_s, wd_s;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]),
    .r0_rdata(rd[0]), .r0_ack(ack[0]),
    .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]),
    .r1_rdata(rd[1]), .r1_ack(ack[1]),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .busy(busy), .owner(owner), .err(err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    req_s  <= req;
    we_s   <= we;
    addr_s <= addr;
    wd_s   <= wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_r0_rdata"}, rd[0], 0);
    chk({tag, "_r1_rdata"}, rd[1], 0);
    chk({tag, "_acks"}, ack, 0);
    chk({tag, "_m_req"}, m_req, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 1);
    chk({tag, "_err"}, err, 0);
  endtask

  // Requester driver: holds fields until ack, sometimes keeps req high as a new transaction.
  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; dir_done = 1'b0;
    forever begin
      @(negedge clk);
      if (mode == 0) begin
        req = '0;
        dir_done = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (req[p] && ack[p]) begin
            if (mode == 2) dir_done = 1'b1;
            if (mode == 1 && $urandom_range(0, 3) == 0) begin
              we[p]    = 1'($urandom_range(0, 1));
              addr[p]  = 16'($urandom);
              wdata[p] = 16'($urandom);
            end else begin
              req[p] = 1'b0;
            end
          end else if (!req[p]) begin
            if (mode == 1 && $urandom_range(0, 2) == 0) begin
              req[p]   = 1'b1;
              we[p]    = 1'($urandom_range(0, 1));
              addr[p]  = 16'($urandom);
              wdata[p] = 16'($urandom);
            end else if (mode == 2 && p == 0 && !dir_done) begin
              req[0]   = 1'b1;
              we[0]    = 1'b0;
              addr[0]  = 16'h0010;
              wdata[0] = 16'h0000;
            end
          end
        end
      end
    end
  end

  // Memory responder plus arbitration reference model; pushes expected completions.
  initial begin : memory_model
    logic             m_req_prev, last_owner, err_model, ack_pending, new_grant, exp_grant, win, to;
    logic [1:0][15:0] rd_model;
    logic [15:0]      ack_data, data;
    int               next_grant, ack_at, lat;
    item_t            it;
    m_ack = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clk);
      if (!run) begin
        m_ack = 1'b0;
        m_req_prev = 1'b0;
        last_owner = 1'b1;
        err_model = 1'b0;
        ack_pending = 1'b0;
        rd_model = '0;
        next_grant = 0;
      end else begin
        new_grant = m_req && !m_req_prev;
        exp_grant = (cyc >= next_grant) && (req_s != 2'b00);
        if (new_grant || exp_grant) chk("grant_timing", new_grant, exp_grant);
        if (new_grant && exp_grant) begin
          win = (req_s == 2'b11) ? ~last_owner : req_s[1];
          chk("grant_owner", owner, win);
          chk("grant_we", m_we, we_s[win]);
          chk("grant_addr", m_addr, addr_s[win]);
          chk("grant_wdata", m_wdata, wd_s[win]);
          last_owner = win;
          to   = ($urandom_range(0, 5) == 0);
          lat  = to ? int'(TO) : int'($urandom_range(1, 3));
          data = 16'($urandom);
          if (!we_s[win]) rd_model[win] = to ? 16'h0000 : data;
          err_model = err_model | to;
          it.port  = int'(win);
          it.due   = cyc + lat;
          it.rdata = rd_model[win];
          it.err   = err_model;
          sbq.push_back(it);
          next_grant = cyc + lat + 2;
          if (!to) begin
            ack_pending = 1'b1;
            ack_at = cyc + lat - 1;
            ack_data = data;
          end
        end
        m_req_prev = m_req;
        if (ack_pending && cyc == ack_at) begin
          m_ack = 1'b1;
          m_rdata = ack_data;
          ack_pending = 1'b0;
        end else if (!m_req && $urandom_range(0, 4) == 0) begin
          m_ack = 1'b1;
          m_rdata = 16'($urandom);
        end else begin
          m_ack = 1'b0;
          m_rdata = 16'($urandom);
        end
      end
    end
  end

  // Monitor: every ack must match the oldest expected completion at its due cycle.
  initial begin : monitor
    logic [1:0][15:0] mon_rd;
    item_t it;
    forever begin
      @(negedge clk);
      if (!run) begin
        sbq.delete();
        mon_rd = '0;
      end else begin
        if (ack != 2'b00) begin
          if (sbq.size() == 0 || sbq[0].due != cyc) begin
            chk("unexpected_ack", ack, 0);
          end else begin
            it = sbq.pop_front();
            chk("ack_port", ack, 32'd1 << it.port);
            chk("ack_rdata", rd[it.port], it.rdata);
            mon_rd[it.port] = it.rdata;
            chk("other_rdata", rd[1 - it.port], mon_rd[1 - it.port]);
            chk("ack_err", err, it.err);
            chk("ack_busy", busy, 1);
          end
        end
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
          it = sbq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_ack port=%0d actual=none required=ack_at_cycle_%0d", it.port, it.due);
        end
      end
    end
  end

  initial begin : main
    bit found;
    rst_n = 1'b0;
    run = 1'b0;
    mode = 0;
    repeat (3) @(negedge clk);
    #1 check_reset("por");
    @(negedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    mode = 1;
    repeat (3000) @(negedge clk);

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (m_req) found = 1'b1;
    end
    chk("midrst_find_busy", found, 1);
    #2 run = 1'b0;
    mode = 0;
    rst_n = 1'b0;
    #1 check_reset("midrst_async");
    repeat (2) @(negedge clk);
    #1 check_reset("midrst_held");
    rst_n = 1'b1;
    chk("post_rst_owner", owner, 1);
    run = 1'b1;
    mode = 2;
    for (int i = 0; i < 30 && !dir_done; i++) @(negedge clk);
    chk("post_rst_r0_served", dir_done, 1);

    mode = 1;
    repeat (1500) @(negedge clk);
    mode = 0;
    repeat (12) @(negedge clk);
    chk("drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
